// File: rtl/fuzz_seq_pkg.sv
// Shared types and constants for the fuzz vector sequencer.
// Vector layout is {wire0, wire1, wire2, wire3}, MSB first.
package fuzz_seq_pkg;

  localparam int VEC_W_D = 72;
  localparam int Y_W_D   = 87;

  localparam int W0_LSB = 51;
  localparam int W0_W   = 21;
  localparam int W1_LSB = 37;
  localparam int W1_W   = 14;
  localparam int W2_LSB = 16;
  localparam int W2_W   = 21;
  localparam int W3_LSB = 0;
  localparam int W3_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sig_misr.sv
// Multiple-input signature register over captured responses.
// Cleared at run start, folded once per accepted capture.
module sig_misr #(
  parameter int             Y_W  = 87,
  parameter logic [Y_W-1:0] POLY = {{(Y_W-1){1'b0}}, 1'b1}
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic [Y_W-1:0] din,
  output logic [Y_W-1:0] sig
);

  // Shift-left with tap feedback, then fold in the new response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[Y_W-2:0], 1'b0}
           ^ (sig[Y_W-1] ? POLY : '0)
           ^ din;
    end
  end

endmodule

// File: rtl/fuzz_vector_sequencer.sv
// Buffers host vectors, replays them into the DUT with a settle
// gap, and streams each response out while signing it.
module fuzz_vector_sequencer
  import fuzz_seq_pkg::*;
#(
  parameter int             VEC_W  = VEC_W_D,
  parameter int             Y_W    = Y_W_D,
  parameter int             DEPTH  = 32,
  parameter int             SETTLE = 1,
  parameter logic [Y_W-1:0] POLY   = {{(Y_W-1){1'b0}}, 1'b1}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [VEC_W-1:0]         load_data,
  input  logic                     clear,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [VEC_W-1:0]         stim,
  input  logic [Y_W-1:0]           dut_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Y_W-1:0]           out_data,
  output logic [$clog2(DEPTH)-1:0] out_idx,
  output logic [Y_W-1:0]           sig
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE + 2);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE);
  localparam state_t AFTER_APPLY = (SETTLE == 0) ? ST_CAPTURE : ST_WAIT;

  state_t           state;
  logic [VEC_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [CW-1:0]    cnt;
  logic             idle;
  logic             wr_en;
  logic             run_go;
  logic             fire;
  logic             last;

  assign idle   = (state == ST_IDLE);
  assign rd_nxt = rd_ptr + AW'(1);
  assign last   = ({1'b0, rd_ptr} == wr_ptr - (AW+1)'(1));

  assign load_ready = idle && (wr_ptr != FULL);
  assign wr_en      = load_valid && load_ready && !clear;
  assign run_go     = idle && start && !clear;
  assign out_valid  = (state == ST_CAPTURE);
  assign fire       = out_valid && out_ready;
  assign out_data   = out_valid ? dut_y : '0;
  assign out_idx    = rd_ptr;
  assign busy       = (state == ST_WAIT) || out_valid;
  assign done       = (state == ST_DONE);

  // Vector storage; contents survive runs so a rerun replays them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= load_data;
  end

  // Run control: load, apply, settle, capture, finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      stim   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (clear) begin
            wr_ptr <= '0;
          end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (start) begin
              if (wr_ptr == '0) begin
                state <= ST_DONE;
              end else begin
                rd_ptr <= '0;
                stim   <= mem[0];
                cnt    <= RELOAD;
                state  <= AFTER_APPLY;
              end
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (out_ready) begin
            if (last) begin
              state <= ST_DONE;
            end else begin
              rd_ptr <= rd_nxt;
              stim   <= mem[rd_nxt];
              cnt    <= RELOAD;
              state  <= AFTER_APPLY;
            end
          end
        end
        ST_DONE: begin
          stim  <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sig_misr #(
    .Y_W  (Y_W),
    .POLY (POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_go),
    .en    (fire),
    .din   (dut_y),
    .sig   (sig)
  );

endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// Randomized scenario bench for fuzz_vector_sequencer.
// Reference: vector queue, timing formula, rotate-xor signature.
module tb_fuzz_vector_sequencer;

  localparam int VEC_W  = 72;
  localparam int Y_W    = 87;
  localparam int DEPTH  = 32;
  localparam int SETTLE = 3;
  localparam int AW     = 5;
  localparam int PER    = SETTLE + 1;

  logic             clk = 0;
  logic             rst_n = 0;
  logic             load_valid = 0;
  logic             load_ready;
  logic [VEC_W-1:0] load_data = '0;
  logic             clear = 0;
  logic             start = 0;
  logic             busy;
  logic             done;
  logic [VEC_W-1:0] stim;
  logic [Y_W-1:0]   dut_y;
  logic             out_valid;
  logic             out_ready;
  logic [Y_W-1:0]   out_data;
  logic [AW-1:0]    out_idx;
  logic [Y_W-1:0]   sig;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic mix = 0;
  logic force_mode = 0;
  int hold_left = 0;
  logic [AW-1:0] hold_idx = '0;

  logic [VEC_W-1:0] mq[$];

  logic [AW-1:0]  h_idx[$];
  logic [Y_W-1:0] h_data[$];
  logic [Y_W-1:0] h_sig[$];
  int             h_cyc[$];
  int             done_cyc[$];
  logic [Y_W-1:0] done_sig[$];
  int valid_cnt, busy_cnt, stall_n, stall_bad;
  logic [VEC_W-1:0] st_stim;
  logic [Y_W-1:0]   st_sig;

  function automatic logic [Y_W-1:0] resp(
    input logic [VEC_W-1:0] v, input logic m);
    logic [14:0] hi;
    hi = m ? (v[14:0] ^ 15'h5a5a) : 15'd0;
    return {hi, v};
  endfunction

  function automatic logic [VEC_W-1:0] rv();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[VEC_W-1:0];
  endfunction

  // Signature with single low tap: rotate left, xor response.
  function automatic logic [Y_W-1:0] sig_ref(input int n, input logic m);
    logic [Y_W-1:0] s;
    s = '0;
    for (int i = 0; i < n; i++)
      s = {s[Y_W-2:0], s[Y_W-1]} ^ resp(mq[i], m);
    return s;
  endfunction

  assign dut_y = force_mode ? ((out_idx == '0) ? 87'd5 : 87'd3)
                            : resp(stim, mix);
  assign out_ready = !(out_valid && out_idx == hold_idx && hold_left > 0);

  fuzz_vector_sequencer #(
    .VEC_W  (VEC_W),
    .Y_W    (Y_W),
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .clear      (clear),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .stim       (stim),
    .dut_y      (dut_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .sig        (sig)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk)
    if (out_valid && out_idx == hold_idx && hold_left > 0)
      hold_left <= hold_left - 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) valid_cnt++;
      if (busy) busy_cnt++;
      if (out_valid && out_ready) begin
        h_idx.push_back(out_idx);
        h_data.push_back(out_data);
        h_sig.push_back(sig);
        h_cyc.push_back(cyc);
      end
      if (out_valid && !out_ready) begin
        if (stall_n == 0) begin
          st_stim = stim;
          st_sig  = sig;
        end else if (stim !== st_stim || sig !== st_sig) begin
          stall_bad++;
        end
        stall_n++;
      end
      if (done) begin
        done_cyc.push_back(cyc);
        done_sig.push_back(sig);
      end
    end
  end

  task automatic clear_mon();
    h_idx.delete(); h_data.delete(); h_sig.delete(); h_cyc.delete();
    done_cyc.delete(); done_sig.delete();
    valid_cnt = 0; busy_cnt = 0; stall_n = 0; stall_bad = 0;
  endtask

  task automatic ld(input logic [VEC_W-1:0] v);
    load_valid = 1; load_data = v;
    @(posedge clk); #1;
    load_valid = 0;
    if (mq.size() < DEPTH) mq.push_back(v);
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    mq.delete();
  endtask

  task automatic pulse_start(output int e);
    start = 1; e = cyc + 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n0;
    n0 = done_cyc.size();
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cyc.size() > n0) begin ok = 1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stim !== '0 || sig !== '0 || busy !== 0 || done !== 0 ||
        out_valid !== 0 || load_ready !== 1) begin
      errors++;
      $display("FAIL reset_in: stim=%h sig=%h busy=%b done=%b ov=%b lr=%b",
               stim, sig, busy, done, out_valid, load_ready);
    end
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (load_ready !== 1 || busy !== 0 || stim !== '0) begin
      errors++;
      $display("FAIL reset_out: lr=%b busy=%b stim=%h", load_ready, busy, stim);
    end
  endtask

  task automatic check_run(input string nm, input int e, input logic m);
    int n;
    n = mq.size();
    checks++;
    if (h_idx.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d want %0d", nm, h_idx.size(), n);
    end
    for (int i = 0; i < n && i < h_idx.size(); i++) begin
      checks++;
      if (h_idx[i] !== AW'(i) || h_data[i] !== resp(mq[i], m)) begin
        errors++;
        $display("FAIL %s_out[%0d]: idx=%0d data=%h want idx=%0d data=%h",
                 nm, i, h_idx[i], h_data[i], i, resp(mq[i], m));
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_sig[0] !== sig_ref(n, m)) begin
      errors++;
      $display("FAIL %s_done: n=%0d sig=%h want %h", nm, done_cyc.size(),
               (done_sig.size() > 0) ? done_sig[0] : '0, sig_ref(n, m));
    end
  endtask

  task automatic test_basic();
    int e; bit ok;
    mix = 0;
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      ld(rv());
      checks++;
      if (load_ready !== 1) begin
        errors++;
        $display("FAIL basic_ready[%0d]: got %b want 1", i, load_ready);
      end
    end
    pulse_start(e);
    wait_done(3 * PER + 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: got 0 want 1"); end
    check_run("basic", e, 0);
    for (int i = 0; i < 3 && i < h_cyc.size(); i++) begin
      checks++;
      if (h_cyc[i] != e + SETTLE + i * PER) begin
        errors++;
        $display("FAIL basic_time[%0d]: got %0d want %0d",
                 i, h_cyc[i], e + SETTLE + i * PER);
      end
    end
    checks++;
    if (done_cyc.size() > 0 && done_cyc[0] != e + 3 * PER) begin
      errors++;
      $display("FAIL basic_done_time: got %0d want %0d", done_cyc[0], e + 3 * PER);
    end
    checks++;
    if (stim !== '0 || busy !== 0) begin
      errors++;
      $display("FAIL basic_after: stim=%h busy=%b want 0 0", stim, busy);
    end
  endtask

  task automatic test_misr();
    int e; bit ok;
    do_clear();
    clear_mon();
    ld(rv()); ld(rv());
    force_mode = 1;
    pulse_start(e);
    wait_done(2 * PER + 20, ok);
    force_mode = 0;
    checks++;
    if (!ok || h_sig.size() != 2) begin
      errors++;
      $display("FAIL misr_run: ok=%0d caps=%0d want 1 2", ok, h_sig.size());
    end else if (h_sig[0] !== '0 || h_sig[1] !== 87'd5) begin
      errors++;
      $display("FAIL misr_step: got %0d,%0d want 0,5", h_sig[0], h_sig[1]);
    end
    checks++;
    if (sig !== 87'd9) begin
      errors++;
      $display("FAIL misr_final: got %0d want 9", sig);
    end
  endtask

  task automatic test_fill();
    int e; bit ok;
    mix = 1;
    do_clear();
    clear_mon();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (load_ready !== 1) begin
        errors++;
        $display("FAIL fill_ready[%0d]: got %b want 1", i, load_ready);
      end
      ld(rv());
    end
    checks++;
    if (load_ready !== 0) begin
      errors++;
      $display("FAIL fill_full: got %b want 0", load_ready);
    end
    ld(rv());
    pulse_start(e);
    wait_done(DEPTH * PER + 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fill_timeout: got 0 want 1"); end
    check_run("fill", e, 1);
  endtask

  task automatic test_stall();
    int e; bit ok;
    mix = 1;
    do_clear();
    clear_mon();
    for (int i = 0; i < 4; i++) ld(rv());
    hold_idx = 1;
    hold_left = 4;
    pulse_start(e);
    wait_done(4 * PER + 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_timeout: got 0 want 1"); end
    check_run("stall", e, 1);
    checks++;
    if (stall_n != 4 || stall_bad != 0) begin
      errors++;
      $display("FAIL stall_hold: cycles=%0d bad=%0d want 4 0", stall_n, stall_bad);
    end
    checks++;
    if (st_stim !== mq[1] || st_sig !== sig_ref(1, 1)) begin
      errors++;
      $display("FAIL stall_state: stim=%h sig=%h want %h %h",
               st_stim, st_sig, mq[1], sig_ref(1, 1));
    end
    if (h_cyc.size() == 4) begin
      checks++;
      if (h_cyc[1] - h_cyc[0] != PER + 4 || h_cyc[2] - h_cyc[1] != PER ||
          h_cyc[3] - h_cyc[2] != PER) begin
        errors++;
        $display("FAIL stall_spacing: got %0d %0d %0d want %0d %0d %0d",
                 h_cyc[1] - h_cyc[0], h_cyc[2] - h_cyc[1], h_cyc[3] - h_cyc[2],
                 PER + 4, PER, PER);
      end
    end
  endtask

  task automatic test_empty();
    int e; bit ok;
    do_clear();
    clear_mon();
    pulse_start(e);
    wait_done(10, ok);
    checks++;
    if (!ok || done_cyc.size() != 1 || done_cyc[0] != e) begin
      errors++;
      $display("FAIL empty_done: ok=%0d n=%0d got cyc %0d want %0d", ok,
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, e);
    end
    checks++;
    if (sig !== '0 || valid_cnt != 0) begin
      errors++;
      $display("FAIL empty_state: sig=%h valids=%0d want 0 0", sig, valid_cnt);
    end
  endtask

  task automatic test_clear_start();
    int e; bit ok;
    ld(rv()); ld(rv());
    clear_mon();
    clear = 1; start = 1;
    @(posedge clk); #1;
    clear = 0; start = 0;
    mq.delete();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (busy_cnt != 0 || done_cyc.size() != 0) begin
      errors++;
      $display("FAIL clrstart_idle: busy=%0d done=%0d want 0 0",
               busy_cnt, done_cyc.size());
    end
    pulse_start(e);
    wait_done(10, ok);
    checks++;
    if (!ok || done_cyc[0] != e || valid_cnt != 0) begin
      errors++;
      $display("FAIL clrstart_empty: ok=%0d valids=%0d want 1 0", ok, valid_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    int e; bit ok; bit hit;
    mix = 0;
    do_clear();
    for (int i = 0; i < 8; i++) ld(rv());
    clear_mon();
    pulse_start(e);
    hit = 0;
    for (int i = 0; i < 8 * PER + 20; i++) begin
      @(negedge clk);
      if (out_valid && out_idx == 5) begin hit = 1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rstmid_reach: got 0 want 1"); end
    checks++;
    if (sig === '0) begin
      errors++;
      $display("FAIL rstmid_presig: got 0 want nonzero");
    end
    rst_n = 0;
    #1;
    checks++;
    if (stim !== '0 || busy !== 0 || out_valid !== 0 ||
        sig !== '0 || load_ready !== 1) begin
      errors++;
      $display("FAIL rstmid_state: stim=%h busy=%b ov=%b sig=%h lr=%b",
               stim, busy, out_valid, sig, load_ready);
    end
    @(posedge clk); #1;
    rst_n = 1;
    mq.delete();
    clear_mon();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_cyc.size() != 0 || busy_cnt != 0) begin
      errors++;
      $display("FAIL rstmid_nodone: done=%0d busy=%0d want 0 0",
               done_cyc.size(), busy_cnt);
    end
    pulse_start(e);
    wait_done(10, ok);
    checks++;
    if (!ok || done_cyc[0] != e) begin
      errors++;
      $display("FAIL rstmid_rerun: ok=%0d want immediate done", ok);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_misr();
    test_fill();
    test_stall();
    test_empty();
    test_clear_start();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
